motor_ramp_ctrl: RTL and testbench



---
 rtl/motor_ramp_ctrl_if.sv | 9 +
 rtl/motor_ramp_ctrl.sv | 160 ++++++++++++++++
 tb/tb_motor_ramp_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/motor_ramp_ctrl_if.sv
// Duty-target offer/accept handshake between the host and the ramp scheduler.
interface motor_ramp_ctrl_if;
  logic [7:0] target;
  logic       target_valid;
  logic       target_ready;

  modport master (output target, output target_valid, input target_ready);
  modport slave  (input target, input target_valid, output target_ready);
endinterface

// File: rtl/motor_ramp_ctrl.sv
// Slew-limited duty scheduler for the Hall-commutated drive, with stall and
// illegal-Hall supervision that latches a fault and forces duty to zero.
module motor_ramp_ctrl #(
  parameter int unsigned RAMP_DIV     = 16,
  parameter int unsigned STEP         = 4,
  parameter int unsigned MIN_DUTY     = 16,
  parameter int unsigned STALL_CYCLES = 50000
) (
  input  logic             RST,
  input  logic             OUT_CLK,
  input  logic             enable,
  motor_ramp_ctrl_if.slave tgt_if,
  input  logic [2:0]       H,
  input  logic             fault_clr,
  output logic [7:0]       duty,
  output logic             busy,
  output logic             at_target,
  output logic             fault,
  output logic [1:0]       fault_code
);

  localparam logic [7:0]  DIV_LAST   = 8'(RAMP_DIV - 1);
  localparam logic [8:0]  STEP9      = 9'(STEP);
  localparam logic [8:0]  MIN9       = 9'(MIN_DUTY);
  localparam logic [15:0] STALL_LAST = 16'(STALL_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RAMP,
    HOLD,
    STOP,
    FLT
  } state_t;

  state_t      state, state_n;
  logic [7:0]  duty_n;
  logic        fault_n;
  logic [1:0]  code_n;
  logic [7:0]  tgt_reg;
  logic [2:0]  hall_s1, hall_s2, hall_prev;
  logic [7:0]  pre, pre_n;
  logic [15:0] stall_cnt, stall_n;

  logic       hall_edge, hall_bad, supervised, armed, stall_hit, ramping, tick;
  logic [7:0] floor_val, up_val, dn_val, stepped;
  logic [8:0] up9;

  assign hall_edge  = hall_s2 != hall_prev;
  // Illegal only when both the current and the previous synchronised sample are 000/111.
  assign hall_bad   = (hall_s2 == 3'b000 || hall_s2 == 3'b111) &&
                      (hall_prev == 3'b000 || hall_prev == 3'b111);
  assign supervised = (state == RAMP) || (state == HOLD) || (state == STOP);
  assign armed      = {1'b0, duty} >= MIN9;
  assign stall_hit  = armed && !hall_edge && (stall_cnt == STALL_LAST);
  assign ramping    = (state == RAMP) || (state == STOP);
  assign tick       = ramping && (pre == DIV_LAST);

  assign floor_val = (state == RAMP) ? tgt_reg : '0;
  assign up9       = {1'b0, duty} + STEP9;
  assign up_val    = (up9 >= {1'b0, floor_val}) ? floor_val : up9[7:0];
  assign dn_val    = ({1'b0, duty} >= ({1'b0, floor_val} + STEP9)) ?
                     8'(duty - STEP9[7:0]) : floor_val;
  assign stepped   = (duty < floor_val) ? up_val :
                     (duty > floor_val) ? dn_val : duty;

  always_comb begin
    state_n = state;
    duty_n  = duty;
    fault_n = fault;
    code_n  = fault_code;
    if (supervised && hall_bad) begin
      state_n = FLT;
      duty_n  = '0;
      fault_n = 1'b1;
      code_n  = 2'b10;
    end else if (supervised && stall_hit) begin
      state_n = FLT;
      duty_n  = '0;
      fault_n = 1'b1;
      code_n  = 2'b01;
    end else begin
      case (state)
        IDLE: begin
          duty_n = '0;
          if (enable && tgt_reg != '0) state_n = RAMP;
        end
        RAMP: begin
          if (!enable) begin
            state_n = STOP;
          end else if (tick) begin
            duty_n = stepped;
            if (stepped == tgt_reg) state_n = HOLD;
          end
        end
        HOLD: begin
          if (!enable)                state_n = STOP;
          else if (tgt_reg != duty)   state_n = RAMP;
        end
        STOP: begin
          if (enable)                 state_n = RAMP;
          else if (duty == '0)        state_n = IDLE;
          else if (tick)              duty_n  = stepped;
        end
        FLT: begin
          duty_n = '0;
          if (fault_clr && !enable) begin
            state_n = IDLE;
            fault_n = 1'b0;
            code_n  = 2'b00;
          end
        end
        default: begin
          state_n = IDLE;
          duty_n  = '0;
        end
      endcase
    end
  end

  always_comb begin
    stall_n = '0;
    if (supervised && state_n != FLT && !hall_edge && armed) stall_n = stall_cnt + 16'd1;
  end

  always_comb begin
    pre_n = '0;
    if (ramping && !tick) pre_n = pre + 8'd1;
  end

  always_ff @(posedge OUT_CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      duty       <= '0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
      tgt_reg    <= '0;
      hall_s1    <= 3'b001;
      hall_s2    <= 3'b001;
      hall_prev  <= 3'b001;
      pre        <= '0;
      stall_cnt  <= '0;
    end else begin
      state      <= state_n;
      duty       <= duty_n;
      fault      <= fault_n;
      fault_code <= code_n;
      hall_s1    <= H;
      hall_s2    <= hall_s1;
      hall_prev  <= hall_s2;
      pre        <= pre_n;
      stall_cnt  <= stall_n;
      if (tgt_if.target_valid && tgt_if.target_ready) tgt_reg <= tgt_if.target;
    end
  end

  assign tgt_if.target_ready = state != FLT;
  assign busy                = state != IDLE;
  assign at_target           = state == HOLD;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed and randomized checks of motor_ramp_ctrl against a behavioural model.
module tb_motor_ramp_ctrl;

  localparam int RAMP_DIV = 4;
  localparam int STEP     = 8;
  localparam int MIN_DUTY = 16;
  localparam int STALL    = 100;

  logic       OUT_CLK = 1'b0;
  logic       RST = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] H = 3'b001;
  logic       fault_clr = 1'b0;
  logic [7:0] duty;
  logic       busy, at_target, fault;
  logic [1:0] fault_code;

  motor_ramp_ctrl_if tif ();

  motor_ramp_ctrl #(
    .RAMP_DIV    (RAMP_DIV),
    .STEP        (STEP),
    .MIN_DUTY    (MIN_DUTY),
    .STALL_CYCLES(STALL)
  ) dut (
    .RST       (RST),
    .OUT_CLK   (OUT_CLK),
    .enable    (enable),
    .tgt_if    (tif.slave),
    .H         (H),
    .fault_clr (fault_clr),
    .duty      (duty),
    .busy      (busy),
    .at_target (at_target),
    .fault     (fault),
    .fault_code(fault_code)
  );

  always #5 OUT_CLK = ~OUT_CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_OFF, M_UP, M_STEADY, M_DOWN, M_TRIP} mode_t;
  mode_t m_mode;
  int    m_duty, m_tgt, m_pre, m_stall, m_fault, m_code;
  int    h1, h2, hp;

  function automatic int approach(input int c, input int g);
    if (c < g) return (c + STEP > g) ? g : c + STEP;
    if (c > g) return (c - STEP < g) ? g : c - STEP;
    return c;
  endfunction

  function automatic bit illegal(input int h);
    return (h == 0) || (h == 7);
  endfunction

  task automatic model_reset();
    m_mode = M_OFF; m_duty = 0; m_tgt = 0; m_pre = 0; m_stall = 0;
    m_fault = 0; m_code = 0; h1 = 1; h2 = 1; hp = 1;
  endtask

  task automatic model_step();
    bit    moving = (m_mode == M_UP) || (m_mode == M_DOWN);
    bit    active = moving || (m_mode == M_STEADY);
    bit    edge_s = (h2 != hp);
    bit    tick   = moving && (m_pre == RAMP_DIV - 1);
    mode_t nm     = m_mode;
    int    nd     = m_duty;
    if (active && illegal(h2) && illegal(hp)) begin
      nm = M_TRIP; nd = 0; m_fault = 1; m_code = 2;
    end else if (active && m_duty >= MIN_DUTY && !edge_s && m_stall + 1 >= STALL) begin
      nm = M_TRIP; nd = 0; m_fault = 1; m_code = 1;
    end else begin
      case (m_mode)
        M_OFF: begin
          nd = 0;
          if (enable && m_tgt != 0) nm = M_UP;
        end
        M_UP: begin
          if (!enable) nm = M_DOWN;
          else if (tick) begin
            nd = approach(m_duty, m_tgt);
            if (nd == m_tgt) nm = M_STEADY;
          end
        end
        M_STEADY: begin
          if (!enable) nm = M_DOWN;
          else if (m_tgt != m_duty) nm = M_UP;
        end
        M_DOWN: begin
          if (enable) nm = M_UP;
          else if (m_duty == 0) nm = M_OFF;
          else if (tick) nd = approach(m_duty, 0);
        end
        default: begin
          nd = 0;
          if (fault_clr && !enable) begin nm = M_OFF; m_fault = 0; m_code = 0; end
        end
      endcase
    end
    m_stall = (active && nm != M_TRIP && !edge_s && m_duty >= MIN_DUTY) ? m_stall + 1 : 0;
    m_pre   = moving ? (m_pre + 1) % RAMP_DIV : 0;
    if (tif.target_valid && m_mode != M_TRIP) m_tgt = int'(tif.target);
    hp = h2; h2 = h1; h1 = int'(H);
    m_mode = nm; m_duty = nd;
  endtask

  always @(posedge OUT_CLK or posedge RST) begin
    if (RST) model_reset();
    else     model_step();
  end

  always @(negedge OUT_CLK) begin
    if (!RST) begin
      check("duty",         int'(duty),              m_duty);
      check("busy",         int'(busy),              int'(m_mode != M_OFF));
      check("at_target",    int'(at_target),         int'(m_mode == M_STEADY));
      check("target_ready", int'(tif.target_ready),  int'(m_mode != M_TRIP));
      check("fault",        int'(fault),             m_fault);
      check("fault_code",   int'(fault_code),        m_code);
    end
  end

  // ---------------- Hall rotation ----------------
  logic [2:0] hall_seq [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
  int  hidx = 0;
  int  hcnt = 0;
  bit  rotate = 1'b0;

  always @(negedge OUT_CLK) begin
    if (rotate) begin
      hcnt++;
      if (hcnt >= 10) begin
        hcnt = 0;
        hidx = (hidx + 1) % 6;
        H = hall_seq[hidx];
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_target(input int v);
    @(negedge OUT_CLK);
    tif.target = 8'(v);
    tif.target_valid = 1'b1;
    @(negedge OUT_CLK);
    tif.target_valid = 1'b0;
    repeat (2) @(negedge OUT_CLK);
  endtask

  function automatic bit cond_met(input int kind, input int val);
    case (kind)
      0:       return at_target;
      1:       return !busy;
      2:       return fault;
      default: return int'(duty) == val;
    endcase
  endfunction

  task automatic wait_cond(input string name, input int kind, input int val, input int limit);
    int i = 0;
    while (!cond_met(kind, val) && i < limit) begin
      @(negedge OUT_CLK);
      i++;
    end
    check(name, int'(cond_met(kind, val)), 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int glitch = 0;
    bit frozen = 1'b0;
    tif.target = '0;
    tif.target_valid = 1'b0;
    repeat (3) @(negedge OUT_CLK);
    check("rst_duty", int'(duty), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_at_target", int'(at_target), 0);
    check("rst_ready", int'(tif.target_ready), 1);
    check("rst_fault", int'(fault), 0);
    check("rst_code", int'(fault_code), 0);
    RST = 1'b0;

    // soft start
    rotate = 1'b1;
    send_target(64);
    enable = 1'b1;
    wait_cond("start_hold", 0, 0, 200);
    check("start_duty", int'(duty), 64);
    check("start_busy", int'(busy), 1);

    // retargeting, including a non-multiple of the step
    send_target(20);
    wait_cond("down_hold", 0, 0, 200);
    check("down_duty", int'(duty), 20);
    send_target(60);
    wait_cond("up_hold", 0, 0, 200);
    check("clamp_duty", int'(duty), 60);

    // soft stop with a resume partway down
    send_target(64);
    wait_cond("hold64", 0, 0, 200);
    enable = 1'b0;
    wait_cond("reach32", 3, 32, 200);
    enable = 1'b1;
    wait_cond("resume_hold", 0, 0, 200);
    check("resume_duty", int'(duty), 64);
    enable = 1'b0;
    wait_cond("stop_idle", 1, 0, 200);
    check("stop_duty", int'(duty), 0);

    // stall
    enable = 1'b1;
    wait_cond("stall_hold", 0, 0, 200);
    rotate = 1'b0;
    wait_cond("stall_fault", 2, 0, 400);
    check("stall_code", int'(fault_code), 1);
    check("stall_duty", int'(duty), 0);
    check("stall_ready", int'(tif.target_ready), 0);
    fault_clr = 1'b1;
    repeat (3) @(negedge OUT_CLK);
    check("clr_enabled", int'(fault), 1);
    enable = 1'b0;
    @(negedge OUT_CLK);
    fault_clr = 1'b0;
    check("clr_fault", int'(fault), 0);
    check("clr_idle", int'(busy), 0);

    // illegal Hall
    rotate = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge OUT_CLK);
    rotate = 1'b0;
    H = 3'b111;
    @(negedge OUT_CLK);
    H = hall_seq[hidx];
    repeat (5) @(negedge OUT_CLK);
    check("glitch1_fault", int'(fault), 0);
    H = 3'b111;
    repeat (2) @(negedge OUT_CLK);
    H = hall_seq[hidx];
    repeat (4) @(negedge OUT_CLK);
    check("glitch2_fault", int'(fault), 1);
    check("glitch2_code", int'(fault_code), 2);
    enable = 1'b0;
    fault_clr = 1'b1;
    @(negedge OUT_CLK);
    fault_clr = 1'b0;
    H = 3'b000;
    repeat (10) @(negedge OUT_CLK);
    check("idle_hall0_fault", int'(fault), 0);
    H = hall_seq[hidx];

    // asynchronous reset mid-operation
    rotate = 1'b1;
    send_target(40);
    enable = 1'b1;
    wait_cond("pre_rst_hold", 0, 0, 200);
    check("pre_rst_duty", int'(duty), 40);
    #1;
    RST = 1'b1;
    tif.target = 8'd99;
    tif.target_valid = 1'b1;
    #1;
    check("async_duty", int'(duty), 0);
    check("async_busy", int'(busy), 0);
    #1;
    RST = 1'b0;
    tif.target_valid = 1'b0;
    repeat (4) @(negedge OUT_CLK);
    check("post_rst_duty", int'(duty), 0);
    check("post_rst_busy", int'(busy), 0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge OUT_CLK);
      if ($urandom_range(99) < 3) enable = ~enable;
      tif.target_valid = ($urandom_range(99) < 8);
      case ($urandom_range(5))
        0:       tif.target = 8'd0;
        1:       tif.target = 8'd255;
        2:       tif.target = 8'($urandom_range(20, 1));
        default: tif.target = 8'($urandom_range(255));
      endcase
      fault_clr = ($urandom_range(99) < 5);
      if (glitch > 0) begin
        glitch--;
        if (glitch == 0) begin
          H = hall_seq[hidx];
          rotate = !frozen;
        end
      end else begin
        int r = int'($urandom_range(999));
        if (r < 4) begin
          glitch = int'($urandom_range(2, 1));
          rotate = 1'b0;
          H = r[0] ? 3'b111 : 3'b000;
        end else if (r < 8) begin
          frozen = !frozen;
          rotate = !frozen;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
